bitplane_shifter: RTL and testbench

Parallel-to-serial converter for one Amiga (OCS/ECS/AGA) bitplane inside Denise's bitplane block. It accepts a 64-bit fetch word on each BPL1DAT-triggered load and shifts it out MSB-first at the lores, hires or super-hires pixel rate. The stream then passes through a 64-stage delay line whose tap is chosen by the playfield scroll value. Eight instances, one per plane, feed the playfield priority logic.

---
 rtl/bitplane_shifter_pkg.sv | 23 ++
 rtl/bitplane_shifter.sv | 81 ++++++++
 tb/tb_bitplane_shifter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/bitplane_shifter_pkg.sv
// Shared constants for the Denise bitplane path: fetch-mode encodings and pixel-rate modes.
// The parent bitplane block imports this package as well.
package bitplane_shifter_pkg;

    localparam logic [1:0] FMODE_16  = 2'b00;
    localparam logic [1:0] FMODE_32A = 2'b01;
    localparam logic [1:0] FMODE_32B = 2'b10;
    localparam logic [1:0] FMODE_64  = 2'b11;

    typedef enum logic [1:0] {LORES, HIRES, SHRES} pix_mode_t;

    // Only the fetched width of a plane word carries pixels; the rest is forced to zero.
    function automatic logic [63:0] fetch_mask(input logic [1:0] fm);
        logic [63:0] m;
        case (fm)
            FMODE_16:             m = 64'hFFFF_0000_0000_0000;
            FMODE_32A, FMODE_32B: m = 64'hFFFF_FFFF_0000_0000;
            default:              m = '1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/bitplane_shifter.sv
// One bitplane's parallel-to-serial shifter followed by a 64-stage scroll delay line.
// The delay-line tap is picked per pixel mode from the playfield scroll value.
import bitplane_shifter_pkg::*;

module bitplane_shifter (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk7_en,
    input  logic        c1,
    input  logic        c3,
    input  logic        load,
    input  logic        hires,
    input  logic        shres,
    input  logic [1:0]  fmode,
    input  logic        aga,
    input  logic [63:0] data_in,
    input  logic [7:0]  scroll,
    output logic        out
);

    pix_mode_t   w_mode;
    logic [1:0]  w_fmode_e;
    logic        w_shift;
    logic        w_load;
    logic [63:0] w_load_data;
    logic [5:0]  w_select;

    logic [63:0] r_shifter;
    logic [63:0] r_scroller;

    always_comb begin
        w_mode = LORES;
        if (shres && aga)
            w_mode = SHRES;
        else if (hires)
            w_mode = HIRES;
    end

    assign w_fmode_e   = aga ? fmode : FMODE_16;
    assign w_load      = clk7_en & load;
    assign w_load_data = data_in & fetch_mask(w_fmode_e);

    always_comb begin
        w_shift = 1'b0;
        case (w_mode)
            SHRES:   w_shift = 1'b1;
            HIRES:   w_shift = (c1 == c3);
            default: w_shift = ~c1 & ~c3;
        endcase
    end

    // Scroll is in super-hires units; slower modes drop the sub-pixel LSBs.
    always_comb begin
        w_select = scroll[7:2];
        case (w_mode)
            SHRES:   w_select = scroll[5:0];
            HIRES:   w_select = scroll[6:1];
            default: w_select = scroll[7:2];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_shifter <= '0;
        else if (w_load)
            r_shifter <= w_load_data;
        else if (w_shift)
            r_shifter <= {r_shifter[62:0], 1'b0};
    end

    // Keeps shifting on a load cycle, taking the outgoing bit of the old word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_scroller <= '0;
        else if (w_shift)
            r_scroller <= {r_scroller[62:0], r_shifter[63]};
    end

    assign out = r_scroller[w_select];

endmodule

// File: tb/tb_bitplane_shifter.sv
// Directed bench for bitplane_shifter: load timing, pixel modes, fetch masks, scroll taps, reset.
module tb_bitplane_shifter;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk7_en;
    logic        c1;
    logic        c3;
    logic        load;
    logic        hires;
    logic        shres;
    logic [1:0]  fmode;
    logic        aga;
    logic [63:0] data_in;
    logic [7:0]  scroll;
    logic        out;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned ph    = 0;
    logic [255:0] trace;

    bitplane_shifter dut (
        .clk     (clk),
        .reset   (reset),
        .clk7_en (clk7_en),
        .c1      (c1),
        .c3      (c3),
        .load    (load),
        .hires   (hires),
        .shres   (shres),
        .fmode   (fmode),
        .aga     (aga),
        .data_in (data_in),
        .scroll  (scroll),
        .out     (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Phase ph applies to the next clock edge: 0=(c1,c3)00, 1=10, 2=11, 3=01 with clk7_en.
    task automatic set_phase();
        c1      = (ph == 1) || (ph == 2);
        c3      = (ph == 2) || (ph == 3);
        clk7_en = (ph == 3);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ph = (ph + 1) % 4;
        set_phase();
    endtask

    task automatic do_load(input logic [63:0] d);
        while (ph != 3) tick();
        load    = 1'b1;
        data_in = d;
        tick();
        load    = 1'b0;
        data_in = '0;
    endtask

    task automatic capture(input int unsigned n);
        trace = '0;
        for (int unsigned i = 0; i < n; i++) begin
            trace[i] = out;
            tick();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    function automatic int unsigned count_ones(input int unsigned n);
        int unsigned c = 0;
        for (int unsigned i = 0; i < n; i++) c += trace[i];
        return c;
    endfunction

    function automatic int unsigned first_one(input int unsigned n);
        for (int unsigned i = 0; i < n; i++)
            if (trace[i]) return i;
        return n;
    endfunction

    initial begin
        reset   = 1'b0;
        load    = 1'b0;
        hires   = 1'b0;
        shres   = 1'b0;
        aga     = 1'b0;
        fmode   = 2'b00;
        data_in = '0;
        scroll  = '0;
        set_phase();
        #1 reset = 1'b1;
        #2 chk("reset_out", 64'(out), 64'd0);
        reset = 1'b0;

        // Lores single pixel, scroll 0
        do_load(64'h8000_0000_0000_0000);
        capture(40);
        chk("lores_first", 64'(first_one(40)), 64'd1);
        chk("lores_count", 64'(count_ones(40)), 64'd4);
        chk("lores_t4", 64'(trace[4]), 64'd1);
        chk("lores_t5", 64'(trace[5]), 64'd0);
        // After 10 lores shifts the pixel sits in scroller[9]
        scroll = 8'h24;
        #1 chk("scroll_live", 64'(out), 64'd1);
        scroll = 8'h27;
        #1 chk("scroll_subpix", 64'(out), 64'd1);
        scroll = 8'h20;
        #1 chk("scroll_other", 64'(out), 64'd0);
        scroll = 8'h00;

        // Hires AAAA
        do_reset();
        hires = 1'b1;
        do_load({16'hAAAA, 48'h0});
        capture(48);
        chk("hires_pattern", 64'(trace[47:0]), 64'h0000_6666_6666);

        // Lores scroll select 2
        do_reset();
        hires  = 1'b0;
        scroll = 8'h08;
        do_load(64'h8000_0000_0000_0000);
        capture(48);
        chk("lscroll_first", 64'(first_one(48)), 64'd9);
        chk("lscroll_count", 64'(count_ones(48)), 64'd4);

        // AGA super-hires, 64-bit fetch
        do_reset();
        scroll = 8'h00;
        aga    = 1'b1;
        shres  = 1'b1;
        fmode  = 2'b11;
        do_load('1);
        capture(80);
        chk("shres_first", 64'(first_one(80)), 64'd1);
        chk("shres_count", 64'(count_ones(80)), 64'd64);
        chk("shres_t64", 64'(trace[64]), 64'd1);
        chk("shres_t65", 64'(trace[65]), 64'd0);

        // Same stimulus with AGA off: lores, 16-bit fetch
        do_reset();
        aga = 1'b0;
        do_load('1);
        capture(80);
        chk("noaga_first", 64'(first_one(80)), 64'd1);
        chk("noaga_count", 64'(count_ones(80)), 64'd64);
        chk("noaga_t61", 64'(trace[61]), 64'd1);
        chk("noaga_t65", 64'(trace[65]), 64'd0);

        // AGA off, scroll 3 is sub-pixel in lores
        do_reset();
        scroll = 8'h03;
        do_load('1);
        capture(80);
        chk("noaga_s3_first", 64'(first_one(80)), 64'd1);
        chk("noaga_s3_count", 64'(count_ones(80)), 64'd64);
        scroll = 8'h00;

        // 32-bit fetch, lores
        do_reset();
        aga   = 1'b1;
        shres = 1'b0;
        fmode = 2'b01;
        do_load('1);
        capture(140);
        chk("f32_count", 64'(count_ones(140)), 64'd128);
        chk("f32_t128", 64'(trace[128]), 64'd1);
        chk("f32_t129", 64'(trace[129]), 64'd0);

        // 32-bit fetch (10), hires
        do_reset();
        hires = 1'b1;
        fmode = 2'b10;
        do_load('1);
        capture(80);
        chk("f32h_first", 64'(first_one(80)), 64'd1);
        chk("f32h_count", 64'(count_ones(80)), 64'd64);
        chk("f32h_t65", 64'(trace[65]), 64'd0);

        // Load without clk7_en is ignored
        do_reset();
        hires = 1'b0;
        aga   = 1'b0;
        fmode = 2'b00;
        while (ph != 0) tick();
        load    = 1'b1;
        data_in = '1;
        tick();
        load    = 1'b0;
        data_in = '0;
        capture(40);
        chk("noen_count", 64'(count_ones(40)), 64'd0);

        // Reload mid-stream drops the rest of the word but not the delay line
        do_reset();
        do_load('1);
        do_load('0);
        capture(40);
        chk("reload_t0", 64'(trace[0]), 64'd1);
        chk("reload_count", 64'(count_ones(40)), 64'd1);

        // Asynchronous reset mid-stream
        do_reset();
        aga   = 1'b1;
        shres = 1'b1;
        fmode = 2'b11;
        do_load('1);
        repeat (10) tick();
        chk("pre_reset", 64'(out), 64'd1);
        #1 reset = 1'b1;
        #1 chk("reset_async", 64'(out), 64'd0);
        #1 reset = 1'b0;
        capture(80);
        chk("reset_clear", 64'(count_ones(80)), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
